// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that serialises N cache-side block requests onto one memory port.
// Define MEM_ARB_WRITE_EN to enable the write path; otherwise every request is a read.
module mem_arbiter_rr #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned BLOCK_W = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]         req_wr_i,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]         resp_done_o,
    output logic [BLOCK_W-1:0]         resp_rdata_o,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_address_o,
    output logic                       mem_wr_en_o,
    output logic [BLOCK_W-1:0]         mem_data_out_o,
    input  logic [BLOCK_W-1:0]         mem_data_in_i,
    input  logic                       mem_data_valid_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCK_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic [IDX_W-1:0]     grant_c;
    logic                 grant_vld_c;
    logic [ADDR_W-1:0]    addr_sel_c;
    logic                 wr_sel_c;
    logic [BLOCK_W-1:0]   wdata_sel_c;
    logic                 wr_cur_c;

`ifdef MEM_ARB_WRITE_EN
    logic                 wr_q, wr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    assign wr_cur_c = wr_q;
`else
    logic                 unused_wr_inputs;
    assign unused_wr_inputs = ^{req_wr_i, req_wdata_i, wr_sel_c, wdata_sel_c};
    assign wr_cur_c         = 1'b0;
`endif

    // Rotating-priority scan starting one past the last served channel.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant_c     = '0;
        grant_vld_c = 1'b0;
        idx         = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((32'(last_q) + off) % NUM_REQ);
            if (!grant_vld_c && req_valid_i[idx]) begin
                grant_vld_c = 1'b1;
                grant_c     = idx;
            end
        end
    end

    always_comb begin
        addr_sel_c  = '0;
        wr_sel_c    = 1'b0;
        wdata_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c == IDX_W'(i)) begin
                addr_sel_c  = req_addr_i[i*ADDR_W +: ADDR_W];
                wr_sel_c    = req_wr_i[i];
                wdata_sel_c = req_wdata_i[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        done_d    = '0;
`ifdef MEM_ARB_WRITE_EN
        wr_d      = wr_q;
        wdata_d   = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    grant_d   = grant_c;
                    addr_d    = addr_sel_c;
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
`ifdef MEM_ARB_WRITE_EN
                    wr_d      = wr_sel_c;
                    wdata_d   = wdata_sel_c;
`endif
                end
            end
            BUSY: begin
                if (mem_data_valid_i) begin
                    mem_req_d = 1'b0;
                    done_d    = NUM_REQ'(1) << grant_q;
                    state_d   = RESP;
                    if (!wr_cur_c) begin
                        rdata_d = mem_data_in_i;
                    end
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            done_q    <= '0;
`ifdef MEM_ARB_WRITE_EN
            wr_q      <= 1'b0;
            wdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
`ifdef MEM_ARB_WRITE_EN
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

    assign resp_done_o   = done_q;
    assign resp_rdata_o  = rdata_q;
    assign mem_req_o     = mem_req_q;
    assign mem_address_o = addr_q;
`ifdef MEM_ARB_WRITE_EN
    assign mem_wr_en_o    = wr_q;
    assign mem_data_out_o = wdata_q;
`else
    assign mem_wr_en_o    = 1'b0;
    assign mem_data_out_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: per-cycle comparison against a transaction model plus directed literal checks.
module tb_mem_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned BW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_wr;
    logic [N*AW-1:0]   req_addr;
    logic [N*BW-1:0]   req_wdata;
    logic [N-1:0]      resp_done_o;
    logic [BW-1:0]     resp_rdata_o;
    logic              mem_req_o;
    logic [AW-1:0]     mem_address_o;
    logic              mem_wr_en_o;
    logic [BW-1:0]     mem_data_out_o;
    logic [BW-1:0]     mem_data_in;
    logic              mdv;

    int tests = 0;
    int fails = 0;
    int cnt   = 0;
    int lat   = 4;
    bit auto_mem = 1'b0;
    logic [N-1:0] hold = '0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wr_i(req_wr), .req_wdata_i(req_wdata),
        .resp_done_o(resp_done_o), .resp_rdata_o(resp_rdata_o),
        .mem_req_o(mem_req_o), .mem_address_o(mem_address_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_data_out_o(mem_data_out_o), .mem_data_in_i(mem_data_in), .mem_data_valid_i(mdv)
    );

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected behaviour: the arbiter walks each request through issue, memory wait and response.
    function automatic int pick_fn(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    int           m_phase, m_ptr, m_pick;
    logic         m_req, m_wr;
    logic [N-1:0] m_done;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_rdata;
    bit           m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_ptr <= N - 1; m_pick <= 0; m_req <= 1'b0; m_wr <= 1'b0;
            m_done <= '0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_live <= 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    m_done <= '0;
                    if (req_valid != '0) begin
                        m_pick <= pick_fn(req_valid, m_ptr);
                        m_addr <= req_addr[pick_fn(req_valid, m_ptr)*AW +: AW];
`ifdef MEM_ARB_WRITE_EN
                        m_wr    <= req_wr[pick_fn(req_valid, m_ptr)];
                        m_wdata <= req_wdata[pick_fn(req_valid, m_ptr)*BW +: BW];
`else
                        m_wr    <= 1'b0;
                        m_wdata <= '0;
`endif
                        m_req   <= 1'b1;
                        m_phase <= 1;
                    end
                end
                1: if (mdv) begin
                    if (!m_wr) m_rdata <= mem_data_in;
                    m_req   <= 1'b0;
                    m_done  <= N'(1) << m_pick;
                    m_phase <= 2;
                end
                default: begin
                    m_done  <= '0;
                    m_ptr   <= m_pick;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_mem_req", BW'(mem_req_o), BW'(m_req));
            chk("cmp_resp_done", BW'(resp_done_o), BW'(m_done));
            chk("cmp_mem_address", BW'(mem_address_o), BW'(m_addr));
            chk("cmp_mem_wr_en", BW'(mem_wr_en_o), BW'(m_wr));
            chk("cmp_mem_data_out", mem_data_out_o, m_wdata);
            chk("cmp_resp_rdata", resp_rdata_o, m_rdata);
        end
    end

    // One cycle of the memory controller and requester behaviour, driven at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (mdv) mdv = 1'b0;
        else if (auto_mem && mem_req_o) begin
            if (cnt >= lat) begin mdv = 1'b1; cnt = 0; end
            else cnt++;
        end
        for (int i = 0; i < N; i++)
            if (resp_done_o[i] && !hold[i]) req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        int n;
        n = 0;
        d = '0;
        while (n < 60) begin
            tick();
            if (resp_done_o != '0) begin d = resp_done_o; return; end
            n++;
        end
        tests++; fails++;
        $display("FAIL wait_done: got timeout expected resp_done pulse");
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    logic [N-1:0] d;
    logic [N-1:0] order [8];
    logic [N-1:0] exp_order [8];
    logic [BW-1:0] pat_a5, pat_3c, pat_55, pat_dead;

    initial begin
        pat_a5 = {16{8'hA5}}; pat_3c = {16{8'h3C}}; pat_55 = {16{8'h55}};
        pat_dead = {8{16'hDEAD}};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem_data_in = pat_a5; mdv = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_mem_req", BW'(mem_req_o), BW'(0));
        chk("reset_resp_done", BW'(resp_done_o), BW'(0));
        chk("reset_rdata", resp_rdata_o, BW'(0));

        // Stray completion with nothing outstanding.
        mdv = 1'b1; tick(); tick();
        chk("idle_mdv_mem_req", BW'(mem_req_o), BW'(0));
        chk("idle_mdv_rdata", resp_rdata_o, BW'(0));
        chk("idle_mdv_done", BW'(resp_done_o), BW'(0));

        // Single read on channel 0.
        auto_mem = 1'b1; cnt = 0;
        req_addr[0 +: AW] = 64'h1000; req_valid[0] = 1'b1;
        tick();
        chk("rd_mem_req_latency", BW'(mem_req_o), BW'(1));
        chk("rd_mem_address", BW'(mem_address_o), BW'(64'h1000));
        chk("rd_mem_wr_en", BW'(mem_wr_en_o), BW'(0));
        wait_done(d);
        chk("rd_resp_done", BW'(d), BW'(4'b0001));
        chk("rd_resp_rdata", resp_rdata_o, pat_a5);
        tick();
        chk("rd_mem_req_low", BW'(mem_req_o), BW'(0));

        // Two simultaneous requests after reset.
        pulse_rst();
        mem_data_in = pat_3c;
        req_addr[1*AW +: AW] = 64'h1100; req_valid = 4'b0011;
        wait_done(d);
        chk("pair_first", BW'(d), BW'(4'b0001));
        wait_done(d);
        chk("pair_second", BW'(d), BW'(4'b0010));

        // All four channels requesting continuously.
        pulse_rst();
        req_addr[2*AW +: AW] = 64'h1200; req_addr[3*AW +: AW] = 64'h1300;
        hold = 4'hF; req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            wait_done(d);
            order[i] = d;
        end
        req_valid = '0; hold = '0;
        for (int i = 0; i < 8; i++) chk("fair_order", BW'(order[i]), BW'(exp_order[i]));
        tick(); tick();

        // Write on channel 1; read data register must survive it.
        mem_data_in = pat_55;
        req_addr[1*AW +: AW] = 64'h2040; req_wdata[1*BW +: BW] = pat_dead;
        req_wr[1] = 1'b1; req_valid[1] = 1'b1;
        tick();
        chk("wr_mem_address", BW'(mem_address_o), BW'(64'h2040));
`ifdef MEM_ARB_WRITE_EN
        chk("wr_mem_wr_en", BW'(mem_wr_en_o), BW'(1));
        chk("wr_mem_data_out", mem_data_out_o, pat_dead);
`else
        chk("wr_mem_wr_en", BW'(mem_wr_en_o), BW'(0));
        chk("wr_mem_data_out", mem_data_out_o, BW'(0));
`endif
        wait_done(d);
        chk("wr_resp_done", BW'(d), BW'(4'b0010));
`ifdef MEM_ARB_WRITE_EN
        chk("wr_rdata_kept", resp_rdata_o, pat_3c);
`else
        chk("wr_rdata_kept", resp_rdata_o, pat_55);
`endif
        req_wr = '0;
        tick();

        // Reset while a transaction is in flight, then a late completion.
        auto_mem = 1'b0;
        req_addr[2*AW +: AW] = 64'h3000; req_valid[2] = 1'b1;
        tick();
        chk("abort_mem_req_up", BW'(mem_req_o), BW'(1));
        tick();
        rst = 1'b1; req_valid = '0;
        tick();
        rst = 1'b0;
        chk("abort_mem_req", BW'(mem_req_o), BW'(0));
        chk("abort_done", BW'(resp_done_o), BW'(0));
        chk("abort_address", BW'(mem_address_o), BW'(0));
        mdv = 1'b1; tick(); tick();
        chk("late_mdv_mem_req", BW'(mem_req_o), BW'(0));
        chk("late_mdv_done", BW'(resp_done_o), BW'(0));

        // Pointer was reset: channel 1 beats channel 2.
        auto_mem = 1'b1; cnt = 0;
        req_addr[1*AW +: AW] = 64'h4000; req_valid = 4'b0110;
        wait_done(d);
        chk("ptr_reset_first", BW'(d), BW'(4'b0010));
        wait_done(d);
        chk("ptr_reset_second", BW'(d), BW'(4'b0100));
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-channel round-robin arbiter between the cache-side requesters (icache, dcache, and later a prefetcher or page-table walker) and the single-ported memory controller. It serialises block-sized read/write requests and drives one memory transaction at a time. Each requester receives a one-cycle completion pulse and the shared read-data register. It generalises the current two-port arbiter to `NUM_REQ` channels with fair rotating priority.

## Interface
- `NUM_REQ`, 2, number of requester channels (≥2)
- `ADDR_W`, 64, address width
- `BLOCK_W`, 512, cache block width (bits per transaction)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-channel request level; held until that channel's `resp_done`
- `req_addr`  in  NUM_REQ*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- `req_wr`  in  NUM_REQ  1 = write, 0 = read
- `req_wdata`  in  NUM_REQ*BLOCK_W  write block, channel i at [i*BLOCK_W +: BLOCK_W]
- `resp_done`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `resp_rdata`  out  BLOCK_W  last read block; valid while `resp_done` is high and held until next read capture
- `mem_req`  out  1  transaction in flight
- `mem_address`  out  ADDR_W  latched address
- `mem_wr_en`  out  1  latched write flag
- `mem_data_out`  out  BLOCK_W  latched write data
- `mem_data_in`  in  BLOCK_W  read data from memory controller
- `mem_data_valid`  in  1  one-cycle completion from memory controller

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any `req_valid`, grant the first asserted channel scanning `(last+1) mod NUM_REQ` upward with wrap. Latch grant index, addr, wr, wdata. Go to BUSY. With no request, stay in IDLE.
- BUSY: `mem_req`=1, latched outputs stable. On `mem_data_valid`: if read, capture `mem_data_in` into `resp_rdata`; go to RESP.
- RESP: `resp_done[grant]`=1 for exactly this cycle, `mem_req`=0, `last`<=grant, go to IDLE.
- `req_valid` is sampled only in IDLE. Changes to unselected channels during BUSY/RESP have no effect.
- `mem_data_valid` outside BUSY is ignored.
- Writes also produce `resp_done`. `resp_rdata` is unchanged by writes.
- Requesters must deassert `req_valid` on the edge ending their `resp_done` cycle. A still-high `req_valid` in IDLE is treated as a new request.

## Timing
- Reset values: state=IDLE, `last`=NUM_REQ-1 (channel 0 wins first), `mem_req`=0, `mem_wr_en`=0, `mem_address`=0, `mem_data_out`=0, `resp_rdata`=0, `resp_done`=0.
- `req_valid` high in IDLE at cycle t -> `mem_req` high at t+1.
- `mem_data_valid` at cycle k (in BUSY) -> `resp_done` at k+1, `mem_req` low at k+1. Next grant can raise `mem_req` at k+3.
- Minimum turnaround: 3 cycles per transaction (IDLE, BUSY, RESP).
- `rst` mid-transaction: next cycle IDLE, `mem_req`=0, no `resp_done` issued, pointer reset. A late `mem_data_valid` is ignored.
- Grant is combinational from `req_valid` and `last` in IDLE only. All outputs are registered.
- Fairness: with all channels continuously requesting, grant order is 0,1,…,NUM_REQ-1,0,…

## Configuration
- `MEM_ARB_WRITE_EN` defined: write path as above.
- `MEM_ARB_WRITE_EN` undefined:
  - `req_wr`/`req_wdata` ignored; every request is treated as a read.
  - `mem_wr_en` tied 0, `mem_data_out` tied 0.
  - No write-data latch registers are synthesised.

## Test plan
- NUM_REQ=2, ch0 read 0x1000, memory returns block 0xA5… after 4 cycles -> `mem_address`=0x1000, `mem_wr_en`=0, `resp_done`=2'b01 one cycle later, `resp_rdata`=0xA5….
- ch0 and ch1 assert in the same cycle after reset -> ch0 served first, then ch1. `resp_done` sequence 01 then 10, no overlap.
- NUM_REQ=4, all channels requesting continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- ch1 write 0x2040 with data 0xDEAD… (`MEM_ARB_WRITE_EN` defined) -> `mem_wr_en`=1, `mem_data_out`=0xDEAD…, `resp_done`=10, `resp_rdata` unchanged. With macro undefined -> `mem_wr_en`=0.
- `rst` pulsed in BUSY -> `mem_req`=0 next cycle, no `resp_done`. A subsequent `mem_data_valid` pulse in IDLE is ignored.
- `mem_data_valid` pulse in IDLE with no requests -> no state change, all outputs stay at reset values.
